alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue stage that turns an RV32IM instruction plus register-file read data into the 5-bit ALU `funct` code and the two ALU operands.
- Sits between the register-read stage and the combinational ALU.
- Accepts one instruction per cycle over a valid/ready handshake.
- Registers its decoded result through a 2-entry skid buffer, so `in_ready` is a flop output.

Parameters:
- XLEN, 32: operand width.
- CNT_W, 16: width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; empties the buffer.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  the stage will accept an instruction this cycle (registered).
- instr  in  32  instruction word.
- pc  in  XLEN  PC of the instruction.
- rs1_data  in  XLEN  rs1 register value.
- rs2_data  in  XLEN  rs2 register value.
- out_valid  out  1  a decoded op is presented.
- out_ready  in  1  downstream consumes the presented op.
- funct  out  5  ALU operation code, 0..17.
- ALUin1  out  XLEN  first ALU operand.
- ALUin2  out  XLEN  second ALU operand.
- illegal  out  1  the presented op came from an undecodable instruction.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Reset values: in_ready=1; out_valid=0; funct=0; ALUin1=0; ALUin2=0; illegal=0; illegal_cnt=0; both buffer entries empty.
- ALU funct codes: add=0, sub=1, sll=2, slt=3, sltu=4, xor=5, sra=6, srl=7, or=8, and=9, mul=10, mulh=11, mulhsu=12, mulhu=13, div=14, divu=15, rem=16, remu=17.
- OP (0110011), funct7=0000000: funct3 0..7 map to add, sll, slt, sltu, xor, srl, or, and.
- OP, funct7=0100000: funct3=000 maps to sub; funct3=101 maps to sra.
- OP, funct7=0000001: funct3 0..7 map to codes 10..17.
- OP operands: ALUin1=rs1_data, ALUin2=rs2_data.
- OP-IMM (0010011): addi, slti, sltiu, xori, ori, andi map to add, slt, sltu, xor, or, and. ALUin2 = sign-extended instr[31:20].
- OP-IMM shifts: slli (funct7=0) maps to sll; srli/srai map to srl/sra, selected by instr[30]. ALUin2 = zero-extended instr[24:20].
- LUI (0110111): add; ALUin1=0, ALUin2={instr[31:12],12'b0}.
- AUIPC (0010111): add; ALUin1=pc, ALUin2=U-immediate.
- LOAD (0000011): add; ALUin1=rs1_data, ALUin2=sign-extended I-immediate.
- STORE (0100011): add; ALUin1=rs1_data, ALUin2=sign-extended S-immediate.
- BRANCH (1100011): beq/bne map to sub; blt/bge map to slt; bltu/bgeu map to sltu. ALUin1=rs1_data, ALUin2=rs2_data.
- Illegal cases: any other opcode, any other funct7/funct3 combination, branch funct3 010/011, a shift-immediate with instr[25]=1, or instr[1:0]!=11.
- Illegal response: funct=0, ALUin1=0, ALUin2=0, illegal=1.
- Accept rule: a transfer happens when in_valid && in_ready. The decoded result appears on the outputs no earlier than the next cycle, so latency is 1 cycle when the buffer is empty.
- Skid buffer: main register drives the outputs; the skid register holds one extra entry.
- in_ready is a register and equals "skid entry empty".
- If the main register is full and not consumed, an accepted op goes into the skid entry and in_ready drops the next cycle.
- On out_valid && out_ready, the skid entry (if full) moves to main. Otherwise main takes the new accept or goes empty.
- Simultaneous accept and consume with skid empty: the new op goes to main with no bubble.
- Presented outputs are held stable while out_valid && !out_ready.
- Ordering is strict FIFO.
- flush has priority over accept and consume in the same cycle: both entries are emptied, out_valid=0, in_ready=1, and any concurrent input is dropped.
- flush leaves illegal_cnt unchanged.
- illegal_cnt increments at accept time for illegal instructions, including ones later flushed, and saturates at 2^CNT_W-1.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

Decomposition:
- Shared package `alu_pkg` holds:
  - the ALU funct localparams (FN_ADD=0 .. FN_REMU=17);
  - RV32 opcode constants;
  - a packed struct {funct[4:0], in1, in2, illegal} used as the buffer entry type.
- The ALU is switched to these constants as well.
- One sub-module: `alu_decode`, purely combinational (instr, pc, rs1_data, rs2_data -> struct).
- alu_issue instantiates `alu_decode` and owns the skid buffer and the counter.

Test Plan:
- Decode, R-type: add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, funct=0, ALUin1=5, ALUin2=7.
- Decode, M-extension and sub: 0x022081B3 -> funct=10; 0x402081B3 -> funct=1.
- Decode, I-type and shifts:
  - 0xFFF00093 (addi x1,x0,-1) -> funct=0, ALUin2=0xFFFFFFFF.
  - 0x40315093 (srai x1,x2,3) -> funct=6, ALUin2=3.
- Decode, U-type: 0x123450B7 (lui) -> ALUin1=0, ALUin2=0x12345000. AUIPC 0x12345097 with pc=0x100 -> ALUin1=0x100, ALUin2=0x12345000.
- Backpressure: out_ready=0, three back-to-back in_valid ops A, B, C.
  - A is presented and held; B is taken into skid; in_ready=0 and C is stalled.
  - Then out_ready=1 -> A, B, C emerge in order, with no loss or duplication.
- Illegal and flush:
  - 0xFFFFFFFF -> illegal=1, funct=0, illegal_cnt=1.
  - flush with two entries buffered -> out_valid=0, in_ready=1 next cycle, illegal_cnt unchanged.
  - rst_n low mid-stall -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU funct codes, RV32 opcodes and issue buffer entry type
// Purpose: constants and types shared by the ALU, its decoder and the issue stage.
// Ports: none (package).
package alu_pkg;

  // Operand width baked into the buffer entry type.
  localparam int ALU_XLEN = 32;

  // ALU operation codes.
  localparam logic [4:0] FN_ADD    = 5'd0;
  localparam logic [4:0] FN_SUB    = 5'd1;
  localparam logic [4:0] FN_SLL    = 5'd2;
  localparam logic [4:0] FN_SLT    = 5'd3;
  localparam logic [4:0] FN_SLTU   = 5'd4;
  localparam logic [4:0] FN_XOR    = 5'd5;
  localparam logic [4:0] FN_SRA    = 5'd6;
  localparam logic [4:0] FN_SRL    = 5'd7;
  localparam logic [4:0] FN_OR     = 5'd8;
  localparam logic [4:0] FN_AND    = 5'd9;
  localparam logic [4:0] FN_MUL    = 5'd10;
  localparam logic [4:0] FN_MULH   = 5'd11;
  localparam logic [4:0] FN_MULHSU = 5'd12;
  localparam logic [4:0] FN_MULHU  = 5'd13;
  localparam logic [4:0] FN_DIV    = 5'd14;
  localparam logic [4:0] FN_DIVU   = 5'd15;
  localparam logic [4:0] FN_REM    = 5'd16;
  localparam logic [4:0] FN_REMU   = 5'd17;

  // RV32 major opcodes (all carry instr[1:0] = 2'b11).
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  // One decoded ALU op, as held in each skid buffer entry.
  typedef struct packed {
    logic [4:0]          funct;
    logic [ALU_XLEN-1:0] in1;
    logic [ALU_XLEN-1:0] in2;
    logic                illegal;
  } alu_op_t;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational RV32IM to ALU funct/operand decoder
// Purpose: map one instruction plus register data to an ALU op entry.
// Ports:
//   i_instr    in  32        instruction word
//   i_pc       in  ALU_XLEN  PC of the instruction
//   i_rs1_data in  ALU_XLEN  rs1 value
//   i_rs2_data in  ALU_XLEN  rs2 value
//   o_op       out alu_op_t  decoded op (illegal response when undecodable)
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]         i_instr,
  input  logic [ALU_XLEN-1:0] i_pc,
  input  logic [ALU_XLEN-1:0] i_rs1_data,
  input  logic [ALU_XLEN-1:0] i_rs2_data,
  output alu_op_t             o_op
);

  logic [6:0]          w_opc;
  logic [2:0]          w_f3;
  logic [6:0]          w_f7;
  logic [ALU_XLEN-1:0] w_imm_i;
  logic [ALU_XLEN-1:0] w_imm_s;
  logic [ALU_XLEN-1:0] w_imm_u;
  logic [ALU_XLEN-1:0] w_shamt;

  assign w_opc   = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_f7    = i_instr[31:25];
  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_shamt = {27'b0, i_instr[24:20]};

  logic                w_ok;
  logic [4:0]          w_fn;
  logic [ALU_XLEN-1:0] w_a;
  logic [ALU_XLEN-1:0] w_b;

  // Opcode constants include instr[1:0]=11, so a compressed/garbage
  // low pair never matches and falls to the illegal default.
  always_comb begin
    w_ok = 1'b1;
    w_fn = FN_ADD;
    w_a  = i_rs1_data;
    w_b  = i_rs2_data;
    case (w_opc)
      OPC_OP: begin
        case (w_f7)
          F7_BASE: begin
            case (w_f3)
              3'd0:    w_fn = FN_ADD;
              3'd1:    w_fn = FN_SLL;
              3'd2:    w_fn = FN_SLT;
              3'd3:    w_fn = FN_SLTU;
              3'd4:    w_fn = FN_XOR;
              3'd5:    w_fn = FN_SRL;
              3'd6:    w_fn = FN_OR;
              default: w_fn = FN_AND;
            endcase
          end
          F7_ALT: begin
            if (w_f3 == 3'd0)      w_fn = FN_SUB;
            else if (w_f3 == 3'd5) w_fn = FN_SRA;
            else                   w_ok = 1'b0;
          end
          F7_MULD: w_fn = FN_MUL + {2'b0, w_f3};
          default: w_ok = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        w_b = w_imm_i;
        case (w_f3)
          3'd0: w_fn = FN_ADD;
          3'd2: w_fn = FN_SLT;
          3'd3: w_fn = FN_SLTU;
          3'd4: w_fn = FN_XOR;
          3'd6: w_fn = FN_OR;
          3'd7: w_fn = FN_AND;
          3'd1: begin
            w_b  = w_shamt;
            w_fn = FN_SLL;
            if (w_f7 != F7_BASE) w_ok = 1'b0;
          end
          default: begin
            // srli/srai: instr[30] picks arithmetic; any other funct7 bit
            // (including instr[25]) makes it illegal.
            w_b = w_shamt;
            if (w_f7 == F7_BASE)     w_fn = FN_SRL;
            else if (w_f7 == F7_ALT) w_fn = FN_SRA;
            else                     w_ok = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        w_a = '0;
        w_b = w_imm_u;
      end
      OPC_AUIPC: begin
        w_a = i_pc;
        w_b = w_imm_u;
      end
      OPC_LOAD:  w_b = w_imm_i;
      OPC_STORE: w_b = w_imm_s;
      OPC_BRANCH: begin
        case (w_f3)
          3'd0, 3'd1: w_fn = FN_SUB;
          3'd4, 3'd5: w_fn = FN_SLT;
          3'd6, 3'd7: w_fn = FN_SLTU;
          default:    w_ok = 1'b0;
        endcase
      end
      default: w_ok = 1'b0;
    endcase
  end

  always_comb begin
    o_op = '0;
    if (w_ok) begin
      o_op.funct = w_fn;
      o_op.in1   = w_a;
      o_op.in2   = w_b;
    end else begin
      o_op.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU issue stage with 2-entry skid buffer and illegal counter
// Purpose: decode one instruction per cycle and present the ALU op through a
//          main/skid register pair with a registered in_ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous buffer flush (wins over accept/consume)
//   in_valid/in_ready     upstream handshake (in_ready registered)
//   instr, pc, rs1_data, rs2_data  instruction and operands
//   out_valid/out_ready   downstream handshake
//   funct, ALUin1, ALUin2, illegal  presented op
//   illegal_cnt           saturating count of accepted illegal instructions
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       funct,
  output logic [XLEN-1:0]  ALUin1,
  output logic [XLEN-1:0]  ALUin2,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  alu_op_t w_dec;

  alu_decode u_decode (
    .i_instr    (instr),
    .i_pc       (pc),
    .i_rs1_data (rs1_data),
    .i_rs2_data (rs2_data),
    .o_op       (w_dec)
  );

  alu_op_t          r_main;
  alu_op_t          r_skid;
  logic             r_main_v;
  logic             r_skid_v;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_illegal_cnt;

  logic w_accept;
  logic w_consume;

  assign w_accept  = in_valid && r_in_ready;
  assign w_consume = r_main_v && out_ready;

  // r_in_ready always tracks !r_skid_v; it is kept as its own flop so the
  // upstream sees a clean register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main        <= '0;
      r_skid        <= '0;
      r_main_v      <= 1'b0;
      r_skid_v      <= 1'b0;
      r_in_ready    <= 1'b1;
      r_illegal_cnt <= '0;
    end else if (flush) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (!r_main_v || w_consume) begin
        if (r_skid_v) begin
          // Skid full implies in_ready was low, so nothing new arrives here.
          r_main     <= r_skid;
          r_main_v   <= 1'b1;
          r_skid_v   <= 1'b0;
          r_in_ready <= 1'b1;
        end else begin
          r_main_v <= w_accept;
          if (w_accept) r_main <= w_dec;
        end
      end else if (w_accept) begin
        r_skid     <= w_dec;
        r_skid_v   <= 1'b1;
        r_in_ready <= 1'b0;
      end
      if (w_accept && w_dec.illegal && (r_illegal_cnt != {CNT_W{1'b1}}))
        r_illegal_cnt <= r_illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_v;
  assign funct       = r_main.funct;
  assign ALUin1      = r_main.in1;
  assign ALUin2      = r_main.in2;
  assign illegal     = r_main.illegal;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue
module tb_alu_issue;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0]      instr;
  logic [XLEN-1:0]  pc, rs1_data, rs2_data, ALUin1, ALUin2;
  logic [4:0]       funct;
  logic [CNT_W-1:0] illegal_cnt;

  alu_issue #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .funct(funct),
    .ALUin1(ALUin1), .ALUin2(ALUin2), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          fn;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   m_cnt;
  int   n_checks;
  int   n_errors;
  logic acc;

  // Mnemonic-level lookup tables indexed by funct3 (-1 = no such instruction).
  localparam int RTAB[8] = '{0, 2, 3, 4, 5, 7, 8, 9};
  localparam int ITAB[8] = '{0, -1, 3, 4, 5, -1, 8, 9};
  localparam int BTAB[8] = '{1, 1, -1, -1, 3, 3, 4, 4};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int fn, f3, f7;
    logic [31:0] a, b;
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    fn = -1;
    a  = r1;
    b  = r2;
    case (ins[6:0])
      7'h33: begin
        if (f7 == 0)       fn = RTAB[f3];
        else if (f7 == 32) fn = (f3 == 0) ? 1 : (f3 == 5) ? 6 : -1;
        else if (f7 == 1)  fn = 10 + f3;
      end
      7'h13: begin
        b = 32'($signed(ins[31:20]));
        if (f3 == 1) begin
          b  = 32'(ins[24:20]);
          fn = (f7 == 0) ? 2 : -1;
        end else if (f3 == 5) begin
          b  = 32'(ins[24:20]);
          fn = (f7 == 0) ? 7 : (f7 == 32) ? 6 : -1;
        end else fn = ITAB[f3];
      end
      7'h37: begin fn = 0; a = 0;  b = ins & 32'hFFFF_F000; end
      7'h17: begin fn = 0; a = p;  b = ins & 32'hFFFF_F000; end
      7'h03: begin fn = 0; b = 32'($signed(ins[31:20])); end
      7'h23: begin fn = 0; b = 32'($signed({ins[31:25], ins[11:7]})); end
      7'h63: fn = BTAB[f3];
      default: fn = -1;
    endcase
    if (ins[1:0] != 2'b11) fn = -1;
    if (fn < 0) begin
      e.fn = 0; e.a = 0; e.b = 0; e.ill = 1'b1;
    end else begin
      e.fn = fn; e.a = a; e.b = b; e.ill = 1'b0;
    end
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".in_ready"}, in_ready, q.size() < 2);
    check({tag, ".out_valid"}, out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check({tag, ".funct"}, funct, q[0].fn);
      check({tag, ".ALUin1"}, ALUin1, q[0].a);
      check({tag, ".ALUin2"}, ALUin2, q[0].b);
      check({tag, ".illegal"}, illegal, q[0].ill);
    end
    check({tag, ".illegal_cnt"}, illegal_cnt, m_cnt);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".in_ready"}, in_ready, 1);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".funct"}, funct, 0);
    check({tag, ".ALUin1"}, ALUin1, 0);
    check({tag, ".ALUin2"}, ALUin2, 0);
    check({tag, ".illegal"}, illegal, 0);
    check({tag, ".illegal_cnt"}, illegal_cnt, 0);
  endtask

  // One clock: drive inputs, advance the FIFO model at the edge, check at negedge.
  task automatic cycle(input string tag, input logic v, input logic [31:0] ins,
                       input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic fl, output logic accepted);
    int sz;
    exp_t e;
    in_valid = v; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
    out_ready = ordy; flush = fl;
    @(posedge clk);
    accepted = 1'b0;
    if (fl) q.delete();
    else begin
      sz = q.size();
      if (sz > 0 && ordy) void'(q.pop_front());
      if (v && sz < 2) begin
        accepted = 1'b1;
        e = ref_decode(ins, p, r1, r2);
        q.push_back(e);
        if (e.ill && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    if ($urandom_range(7) == 0) return r;
    k = $urandom_range(6);
    case (k)
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h37;
      3: r[6:0] = 7'h17;
      4: r[6:0] = 7'h03;
      5: r[6:0] = 7'h23;
      default: r[6:0] = 7'h63;
    endcase
    case ($urandom_range(3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    n_checks = 0; n_errors = 0; m_cnt = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    cycle("add",   1, 32'h002081B3, 0, 5, 7, 1, 0, acc);
    check("add.fn_const", funct, 0);
    cycle("mul",   1, 32'h022081B3, 0, 5, 7, 1, 0, acc);
    check("mul.fn_const", funct, 10);
    cycle("sub",   1, 32'h402081B3, 0, 9, 4, 1, 0, acc);
    cycle("addi",  1, 32'hFFF00093, 0, 0, 0, 1, 0, acc);
    check("addi.imm_const", ALUin2, 32'hFFFF_FFFF);
    cycle("srai",  1, 32'h40315093, 0, 1, 2, 1, 0, acc);
    check("srai.fn_const", funct, 6);
    cycle("lui",   1, 32'h123450B7, 0, 3, 3, 1, 0, acc);
    cycle("auipc", 1, 32'h12345097, 32'h100, 3, 3, 1, 0, acc);
    check("auipc.in1_const", ALUin1, 32'h100);
    cycle("drain", 0, 0, 0, 0, 0, 1, 0, acc);

    // Backpressure: A held, B into skid, C stalled, then all drain in order.
    cycle("bpA", 1, 32'h002081B3, 0, 32'hA, 1, 0, 0, acc);
    cycle("bpB", 1, 32'h402081B3, 0, 32'hB, 2, 0, 0, acc);
    cycle("bpC", 1, 32'h022081B3, 0, 32'hC, 3, 0, 0, acc);
    check("bpC.stalled", acc, 0);
    cycle("bpC2", 1, 32'h022081B3, 0, 32'hC, 3, 0, 0, acc);
    begin
      bit c_done;
      c_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
        cycle("bpdrain", !c_done, 32'h022081B3, 0, 32'hC, 3, 1, 0, acc);
        if (acc) c_done = 1'b1;
      end
      check("bpC.accepted", c_done, 1);
    end

    // Illegal word, then flush with two buffered entries.
    cycle("ill", 1, 32'hFFFFFFFF, 0, 1, 1, 1, 0, acc);
    check("ill.cnt_const", illegal_cnt, 1);
    cycle("flX", 1, 32'h00000000, 0, 1, 1, 0, 0, acc);
    cycle("flY", 1, 32'h002081B3, 0, 1, 1, 0, 0, acc);
    cycle("flush", 1, 32'h002081B3, 0, 1, 1, 0, 1, acc);
    check("flush.out_valid_const", out_valid, 0);

    // Counter saturation.
    for (int i = 0; i < 20; i++) cycle("sat", 1, 32'hFFFF_FFFC, 0, 0, 0, 1, 0, acc);
    check("sat.cnt_const", illegal_cnt, (1 << CNT_W) - 1);

    // Asynchronous reset in the middle of a stall.
    cycle("rsA", 1, 32'h002081B3, 0, 1, 2, 0, 0, acc);
    cycle("rsB", 1, 32'h002081B3, 0, 3, 4, 0, 0, acc);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    q.delete(); m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      cycle("rand", $urandom_range(3) != 0, rand_instr(), $urandom, $urandom, $urandom,
            $urandom_range(4) > 1, $urandom_range(40) == 0, acc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
